// File: rtl/hawk_compdecomp_ctrl_pkg.sv
// Shared types for the Hawk compress/decompress initiator controller.
package hawk_compdecomp_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_LOAD,
    ST_ACTIVE,
    ST_RESP
  } state_t;

  localparam logic OP_COMP   = 1'b0;
  localparam logic OP_DECOMP = 1'b1;

  // Widest tag the response record can carry; TAG_W must not exceed it.
  localparam int RSP_TAG_MAX = 16;

  typedef logic [13:0] comp_size_t;

  typedef struct packed {
    logic [RSP_TAG_MAX-1:0] tag;
    logic                   op;
    comp_size_t             size;
    logic                   compressible;
    logic                   err;
  } rsp_t;

endpackage

// File: rtl/hawk_compdecomp_ctrl.sv
// Sequences one page compress/decompress: wait for the page load, hold start
// until the matching done (or timeout), then hold a response until accepted.
module hawk_compdecomp_ctrl
  import hawk_compdecomp_ctrl_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter comp_size_t COMP_THRESH    = 14'd2048,
  parameter int         TAG_W          = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             load_done,
  output logic             comp_start,
  input  logic             comp_done,
  output logic             decomp_start,
  input  logic             decomp_done,
  input  logic [13:0]      comp_size,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_op,
  output logic [13:0]      rsp_size,
  output logic             rsp_compressible,
  output logic             rsp_err,
  output logic             busy,
  output logic [15:0]      stat_comp_ok
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t           state_q, state_d;
  rsp_t             rsp_q;
  logic             load_seen_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      stat_q;
  logic             match_done;
  logic             timeout;

  assign match_done = (rsp_q.op == OP_DECOMP) ? decomp_done : comp_done;
  assign timeout    = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (req_valid)                state_d = ST_WAIT_LOAD;
      ST_WAIT_LOAD: if (load_done || load_seen_q) state_d = ST_ACTIVE;
      ST_ACTIVE:    if (match_done || timeout)    state_d = ST_RESP;
      ST_RESP:      if (rsp_ready)                state_d = ST_IDLE;
      default:                                    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      load_seen_q <= 1'b0;
      cnt_q       <= '0;
      rsp_q       <= '0;
      stat_q      <= '0;
    end else begin
      state_q <= state_d;

      // The read engine may finish loading before the request shows up.
      if (state_q == ST_IDLE && load_done)
        load_seen_q <= 1'b1;
      else if (state_q == ST_WAIT_LOAD && state_d == ST_ACTIVE)
        load_seen_q <= 1'b0;

      if (state_q == ST_WAIT_LOAD)
        cnt_q <= '0;
      else if (state_q == ST_ACTIVE && !timeout)
        cnt_q <= cnt_q + 1'b1;

      if (state_q == ST_IDLE && req_valid) begin
        rsp_q.tag          <= RSP_TAG_MAX'(req_tag);
        rsp_q.op           <= req_op;
        rsp_q.size         <= '0;
        rsp_q.compressible <= 1'b0;
        rsp_q.err          <= 1'b0;
      end

      // Done beats timeout when both land in the same cycle.
      if (state_q == ST_ACTIVE && state_d == ST_RESP) begin
        rsp_q.err          <= !match_done;
        rsp_q.size         <= (match_done && rsp_q.op == OP_COMP) ? comp_size : '0;
        rsp_q.compressible <= match_done && (rsp_q.op == OP_COMP) &&
                              (comp_size <= COMP_THRESH);
      end

      if (state_q == ST_RESP && rsp_ready && rsp_q.compressible && stat_q != 16'hFFFF)
        stat_q <= stat_q + 16'd1;
    end
  end

  assign req_ready        = (state_q == ST_IDLE);
  assign busy             = (state_q != ST_IDLE);
  assign rsp_valid        = (state_q == ST_RESP);
  assign comp_start       = (state_q == ST_ACTIVE) && (rsp_q.op == OP_COMP);
  assign decomp_start     = (state_q == ST_ACTIVE) && (rsp_q.op == OP_DECOMP);
  assign rsp_tag          = TAG_W'(rsp_q.tag);
  assign rsp_op           = rsp_q.op;
  assign rsp_size         = rsp_q.size;
  assign rsp_compressible = rsp_q.compressible;
  assign rsp_err          = rsp_q.err;
  assign stat_comp_ok     = stat_q;

endmodule

// File: tb/tb_hawk_compdecomp_ctrl.sv
// Scoreboard bench: driver pushes expected responses, a negedge monitor pops and checks.
module tb_hawk_compdecomp_ctrl;

  localparam int          TO = 8;
  localparam int          TW = 8;
  localparam logic [13:0] TH = 14'd2048;

  logic          clk;
  logic          rst_i;
  logic          req_valid, req_ready, req_op;
  logic [TW-1:0] req_tag;
  logic          load_done;
  logic          comp_start, comp_done, decomp_start, decomp_done;
  logic [13:0]   comp_size;
  logic          rsp_valid, rsp_ready, rsp_op, rsp_compressible, rsp_err, busy;
  logic [TW-1:0] rsp_tag;
  logic [13:0]   rsp_size;
  logic [15:0]   stat_comp_ok;

  hawk_compdecomp_ctrl #(.TIMEOUT_CYCLES(TO), .COMP_THRESH(TH), .TAG_W(TW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_tag(req_tag),
    .load_done(load_done),
    .comp_start(comp_start), .comp_done(comp_done),
    .decomp_start(decomp_start), .decomp_done(decomp_done),
    .comp_size(comp_size),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag), .rsp_op(rsp_op),
    .rsp_size(rsp_size), .rsp_compressible(rsp_compressible), .rsp_err(rsp_err),
    .busy(busy), .stat_comp_ok(stat_comp_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  typedef struct {
    logic [7:0]  tag;
    logic        op;
    logic [13:0] size;
    logic        compr;
    logic        err;
    int          starts;
  } exp_t;

  exp_t sbq[$];
  int   model_stat = 0;

  // ---------------- monitor ----------------
  int          comp_cyc = 0, decomp_cyc = 0;
  bit          stat_pend = 0, have_prev = 0, prev_start = 0;
  logic [31:0] prev_rsp;

  always @(negedge clk) begin
    exp_t e;
    logic [31:0] cur;
    if (rst_i) begin
      comp_cyc = 0; decomp_cyc = 0; have_prev = 0; prev_start = 0; stat_pend = 0;
      model_stat = 0;
    end else begin
      if (stat_pend) begin
        chk("stat_comp_ok", stat_comp_ok, model_stat);
        stat_pend = 0;
      end
      if (comp_start)   comp_cyc++;
      if (decomp_start) decomp_cyc++;
      if (prev_start && !(comp_start || decomp_start))
        chk("rsp_valid_when_start_falls", rsp_valid, 1);
      prev_start = comp_start || decomp_start;
      if (rsp_valid) begin
        cur = {7'd0, rsp_tag, rsp_op, rsp_size, rsp_compressible, rsp_err};
        chk("req_ready_low_in_resp", req_ready, 0);
        if (have_prev) chk("rsp_stable_under_backpressure", cur, prev_rsp);
        prev_rsp  = cur;
        have_prev = 1;
        if (rsp_ready) begin
          if (sbq.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_rsp tag=%0h with empty scoreboard", rsp_tag);
          end else begin
            e = sbq.pop_front();
            chk("rsp_tag", rsp_tag, e.tag);
            chk("rsp_op", rsp_op, e.op);
            chk("rsp_size", rsp_size, e.size);
            chk("rsp_compressible", rsp_compressible, e.compr);
            chk("rsp_err", rsp_err, e.err);
            chk("comp_start_cycles", comp_cyc, e.op ? 0 : e.starts);
            chk("decomp_start_cycles", decomp_cyc, e.op ? e.starts : 0);
            if (e.compr && model_stat < 16'hFFFF) model_stat++;
          end
          stat_pend = 1;
          comp_cyc = 0; decomp_cyc = 0; have_prev = 0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  // d = ACTIVE cycle (0-based) in which the matching done fires; d >= TO means none.
  task automatic txn(input logic op, input logic [7:0] tag, input bit early, input int ldly,
                     input int d, input logic [13:0] sz, input bit stray, input int bp);
    exp_t e;
    bit   err, m, o;
    int   w;
    err      = (d >= TO);
    e.tag    = tag;
    e.op     = op;
    e.err    = err;
    e.size   = (!err && op == 1'b0) ? sz : 14'd0;
    e.compr  = (op == 1'b0) && !err && (sz <= TH);
    e.starts = err ? TO : d + 1;

    if (early) begin
      load_done = 1'b1; step(); load_done = 1'b0;
    end
    w = 0;
    while (!req_ready && w < 50) begin step(); w++; end
    chk("req_ready_before_req", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_tag = tag;
    sbq.push_back(e);
    step();
    req_valid = 1'b0; req_op = 1'($urandom); req_tag = 8'($urandom);
    chk("busy_after_accept", busy, 1);
    if (early) begin
      chk("no_start_in_wait_load", {30'd0, comp_start, decomp_start}, 0);
      step();
    end else begin
      repeat (ldly) step();
      load_done = 1'b1; step(); load_done = 1'b0;
    end
    chk("start_on_active_entry", {30'd0, comp_start, decomp_start}, op ? 2 'b01 : 2'b10);

    for (int k = 0; k < e.starts; k++) begin
      m = !err && (k == d);
      o = stray && (k == 0) && !m;
      comp_done   = op ? o : m;
      decomp_done = op ? m : o;
      comp_size   = (m && !op) ? sz : 14'($urandom);
      step();
      comp_done = 1'b0; decomp_done = 1'b0;
    end
    chk("rsp_valid_at_expected_cycle", rsp_valid, 1);
    repeat (bp) step();
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
  endtask

  task automatic reset_mid_active();
    req_valid = 1'b1; req_op = 1'($urandom); req_tag = 8'hC3;
    step();
    req_valid = 1'b0;
    load_done = 1'b1; step(); load_done = 1'b0;
    step(); step();
    chk("mid_active_busy", busy, 1);
    rst_i = 1'b1; step(); rst_i = 1'b0;
    chk("rst_comp_start", comp_start, 0);
    chk("rst_decomp_start", decomp_start, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_stat", stat_comp_ok, 0);
    rsp_ready = 1'b1;
    repeat (12) step();
    chk("no_rsp_after_reset", rsp_valid, 0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [13:0] sz;
    rst_i = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_tag = '0; load_done = 1'b0;
    comp_done = 1'b0; decomp_done = 1'b0; comp_size = '0; rsp_ready = 1'b0;
    repeat (3) step();
    chk("reset_outputs",
        {7'd0, comp_start, decomp_start, rsp_valid, rsp_err, rsp_compressible, busy,
         rsp_op, rsp_tag, rsp_size}, 0);
    chk("reset_stat", stat_comp_ok, 0);
    rst_i = 1'b0;
    step();
    chk("req_ready_after_reset", req_ready, 1);

    txn(1'b0, 8'h5A, 1'b0, 1, 3, 14'd64,   1'b0, 0);
    txn(1'b0, 8'h11, 1'b0, 0, 0, 14'd2049, 1'b0, 0);
    txn(1'b0, 8'h12, 1'b0, 0, 1, 14'd2048, 1'b0, 1);
    txn(1'b1, 8'h21, 1'b0, 2, 2, 14'd100,  1'b1, 0);
    txn(1'b0, 8'h31, 1'b0, 0, TO, 14'd10,  1'b0, 0);
    txn(1'b0, 8'h32, 1'b0, 0, TO - 1, 14'd5, 1'b0, 0);
    txn(1'b1, 8'h33, 1'b0, 1, TO, 14'd5,   1'b1, 0);
    txn(1'b0, 8'h41, 1'b1, 0, 1, 14'd100,  1'b0, 5);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       sz = TH;
        1:       sz = TH + 14'd1;
        default: sz = 14'($urandom);
      endcase
      txn(1'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 3),
          $urandom_range(0, TO + 1), sz, ($urandom_range(0, 2) == 0), $urandom_range(0, 5));
    end

    reset_mid_active();
    txn(1'b0, 8'h77, 1'b0, 0, 0, 14'd1, 1'b0, 0);
    repeat (3) step();
    chk("scoreboard_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hawk_compdecomp_ctrl.md
# hawk_compdecomp_ctrl

Initiator-side controller for the Hawk compression/decompression engine. Accepts one page-level compress or decompress request at a time from the page-management FSM and waits until the read engine has loaded the page into the read FIFO. It then drives the engine's `comp_start`/`decomp_start`, holds it until the matching done arrives, captures the reported compressed size, and returns a response with compressibility and timeout status. It sits between the Hawk page-management FSM and `hawk_comdecomp`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: maximum cycles in ACTIVE before the operation is aborted with an error.
- `COMP_THRESH`, default 14'd2048: a page is compressible when `comp_size <= COMP_THRESH`.
- `TAG_W`, default 8: width of the request/response tag.

Ports:
- `clk_i`, input, 1: clock. One clock domain; reset is synchronous and active-high.
- `rst_i`, input, 1: synchronous active-high reset.
- `req_valid`, input, 1: request valid.
- `req_ready`, output, 1: controller can accept a request.
- `req_op`, input, 1: 0 = compress, 1 = decompress.
- `req_tag`, input, TAG_W: opaque tag, returned unchanged.
- `load_done`, input, 1: single-cycle pulse from the read engine when the page is fully written into the read FIFO.
- `comp_start`, output, 1: start compression.
- `comp_done`, input, 1: compression done.
- `decomp_start`, output, 1: start decompression.
- `decomp_done`, input, 1: decompression done.
- `comp_size`, input, 14: compressed size in bytes. Valid in the cycle in which `comp_done` is high.
- `rsp_valid`, output, 1: response valid.
- `rsp_ready`, input, 1: response accepted.
- `rsp_tag`, output, TAG_W: tag of the completed request.
- `rsp_op`, output, 1: operation that completed.
- `rsp_size`, output, 14: captured `comp_size`. Zero for decompress and for timeouts.
- `rsp_compressible`, output, 1: `rsp_op == 0 && !rsp_err && rsp_size <= COMP_THRESH`.
- `rsp_err`, output, 1: operation timed out.
- `busy`, output, 1: high in every state except IDLE.
- `stat_comp_ok`, output, 16: saturating count of compressible compress completions.

## Operation
States are IDLE, WAIT_LOAD, ACTIVE and RESP.

- **IDLE:** `req_ready = 1`. On `req_valid`, latch `req_op` and `req_tag`, then go to WAIT_LOAD.
- **WAIT_LOAD:** on `load_done`, go to ACTIVE. A `load_done` pulse arriving while in IDLE is latched into a sticky flag. WAIT_LOAD treats that flag like `load_done`, and the flag is cleared when ACTIVE is entered.
- **ACTIVE:**
  - `comp_start` is high when op = 0; `decomp_start` is high when op = 1. Both are registered and decoded from the state.
  - The timeout counter starts at 0 on entry and increments every cycle.
  - The done that matches the latched op ends the operation; the other done is ignored. On the matching done, capture `comp_size` (compress only) and go to RESP with `rsp_err = 0`.
  - If counter = `TIMEOUT_CYCLES-1` and no matching done is seen, go to RESP with `rsp_err = 1` and `rsp_size = 0`.
  - If done and timeout occur in the same cycle, done wins.
- **RESP:** `rsp_valid = 1`, and all `rsp_*` outputs are stable until `rsp_ready`. On `rsp_valid && rsp_ready`, go to IDLE. `stat_comp_ok` increments (saturating at 16'hFFFF) in the RESP→IDLE cycle when `rsp_compressible`.
- **Reset** (at any point, including mid-ACTIVE): state = IDLE and the sticky flag is cleared. `comp_start`, `decomp_start`, `rsp_valid`, `rsp_err`, `rsp_compressible`, `busy` and `stat_comp_ok` are 0, and `rsp_size`/`rsp_tag`/`rsp_op` are 0. `req_ready` is 1 in the first cycle after reset deasserts. An in-flight operation is dropped with no response.

## Timing
- Request accepted at edge N; state is WAIT_LOAD at N+1.
- `load_done` at edge M moves the state to ACTIVE at M+1; start is high from M+1.
- Matching done sampled at edge D: start is low and `rsp_valid` is high from D+1. Start is therefore high for a minimum of 1 cycle.
- Timeout: with start first high in cycle S, `rsp_valid` rises at S+`TIMEOUT_CYCLES`.
- Earliest response is 3 cycles after request acceptance, given `load_done` in the first WAIT_LOAD cycle and done in the first ACTIVE cycle.
- `req_ready` is combinational from state only. There is no combinational path from `req_valid` to `req_ready` or from `rsp_ready` to `rsp_valid`.
- The counter is `$clog2(TIMEOUT_CYCLES)` bits wide and never wraps; it is held in states other than ACTIVE.

## Structure
- The shared hawk package holds: an enum for the 4 states; `OP_COMP = 1'b0` and `OP_DECOMP = 1'b1`; a 14-bit `comp_size_t` typedef; and a packed `rsp_t` struct carrying tag, op, size, compressible and err.
- The design is a single module with no sub-modules. The saturating statistics counter is inline.

## Test plan
- **Compress, compressible:** req op=0, tag=8'h5A; `load_done` 2 cycles later; `comp_done` with `comp_size=64` after 3 ACTIVE cycles → `rsp_valid`, tag 5A, size 64, compressible=1, err=0; `stat_comp_ok` = 1 after the handshake.
- **Compress, incompressible:** `comp_size=2049` → compressible=0, `stat_comp_ok` unchanged. Repeat with `comp_size=2048` → compressible=1 (boundary).
- **Decompress:** op=1; a stray `comp_done` in ACTIVE is ignored; `decomp_done` ends the operation → size 0, compressible=0; `comp_start` is never high.
- **Timeout:** `TIMEOUT_CYCLES=8`, no done → `rsp_valid` rises exactly 8 cycles after start rises, err=1, size 0. Also, done in the final cycle → err=0.
- **Backpressure and early load:** `load_done` pulsed while IDLE, then req → ACTIVE one cycle after WAIT_LOAD is entered. `rsp_ready` held low for 5 cycles → outputs stable, `req_ready` = 0 throughout.
- **Reset mid-ACTIVE:** assert `rst_i` for one cycle → next cycle start = 0, `rsp_valid` = 0, `req_ready` = 1, no response emitted.
